// File: rtl/pe_pkg.sv
// Shared types for the context-driven PEA processing element.
// Defines the context-word layout, opcode and operand-select encodings.
// Direction indices fix the bit order of out_mask and out_valid.
package pe_pkg;

  // Context word width is tied to the pe_cfg_t layout below.
  localparam int CFG_W = 16;

  // Port index order shared by out_mask, out_valid and the neighbour arrays.
  localparam int DIR_E = 0;
  localparam int DIR_S = 1;
  localparam int DIR_W = 2;
  localparam int DIR_N = 3;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_PASS = 3'd6,
    OP_MAX  = 3'd7
  } opcode_e;

  // Codes 5..7 all select a zero operand.
  typedef enum logic [2:0] {
    SEL_E   = 3'd0,
    SEL_S   = 3'd1,
    SEL_W   = 3'd2,
    SEL_N   = 3'd3,
    SEL_ACC = 3'd4,
    SEL_Z5  = 3'd5,
    SEL_Z6  = 3'd6,
    SEL_Z7  = 3'd7
  } opsel_e;

  typedef struct packed {
    logic [3:0] out_mask;  // [15:12]
    opsel_e     op1_sel;   // [11:9]
    opsel_e     op2_sel;   // [8:6]
    opcode_e    opcode;    // [5:3]
    logic       acc_wr;    // [2]
    logic       last;      // [1]
    logic       rsvd;      // [0] ignored on read
  } pe_cfg_t;

endpackage

// File: rtl/pe_alu.sv
// Combinational ALU for the processing element; unsigned, modulo 2^DW.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
module pe_alu
  import pe_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] op1,
  input  logic [DW-1:0] op2,
  input  opcode_e       opcode,
  output logic [DW-1:0] result
);

  // Select the operation; MUL keeps only the low DW bits of the product.
  always_comb begin
    result = '0;
    unique case (opcode)
      OP_ADD:  result = op1 + op2;
      OP_SUB:  result = op1 - op2;
      OP_MUL:  result = op1 * op2;
      OP_AND:  result = op1 & op2;
      OP_OR:   result = op1 | op2;
      OP_XOR:  result = op1 ^ op2;
      OP_PASS: result = op1;
      OP_MAX:  result = (op1 > op2) ? op1 : op2;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/pe_ctx.sv
// PEA processing element stepping through a small context memory, one context per fire.
// Latency: 1 cycle from the fire edge to out_*, out_valid and acc.
// Backpressure: in_valid=0 while running stalls in place; run=0 drops back to IDLE.
module pe_ctx
  import pe_pkg::*;
#(
  parameter int DW        = 8,
  parameter int CTX_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [$clog2(CTX_DEPTH)-1:0] cfg_addr,
  input  logic [CFG_W-1:0]             cfg_data,
  input  logic                         run,
  input  logic                         in_valid,
  input  logic [DW-1:0]                in_e,
  input  logic [DW-1:0]                in_s,
  input  logic [DW-1:0]                in_w,
  input  logic [DW-1:0]                in_n,
  output logic [DW-1:0]                out_e,
  output logic [DW-1:0]                out_s,
  output logic [DW-1:0]                out_w,
  output logic [DW-1:0]                out_n,
  output logic [3:0]                   out_valid,
  output logic [DW-1:0]                acc,
  output logic [$clog2(CTX_DEPTH)-1:0] ctx_idx,
  output logic                         busy
);

  localparam int AW = $clog2(CTX_DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  pe_cfg_t       ctx_q [CTX_DEPTH];
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] out_q [4];
  logic [DW-1:0] out_d [4];
  logic [3:0]    vld_q, vld_d;

  logic [DW-1:0] nbr [4];
  logic [DW-1:0] op1, op2, result;
  pe_cfg_t       cur;
  logic          fire;
  logic          rsvd_unused;

  assign nbr[DIR_E] = in_e;
  assign nbr[DIR_S] = in_s;
  assign nbr[DIR_W] = in_w;
  assign nbr[DIR_N] = in_n;

  // The active context is read before any same-cycle write lands.
  assign cur         = ctx_q[idx_q];
  assign rsvd_unused = cur.rsvd;
  assign fire        = (state_q == ST_RUN) && run && in_valid;

  // Operand source: a neighbour, the registered accumulator, or zero.
  function automatic logic [DW-1:0] pick(input opsel_e sel, input logic [DW-1:0] a);
    logic [DW-1:0] v;
    v = '0;
    case (sel)
      SEL_E:   v = nbr[DIR_E];
      SEL_S:   v = nbr[DIR_S];
      SEL_W:   v = nbr[DIR_W];
      SEL_N:   v = nbr[DIR_N];
      SEL_ACC: v = a;
      default: v = '0;
    endcase
    return v;
  endfunction

  assign op1 = pick(cur.op1_sel, acc_q);
  assign op2 = pick(cur.op2_sel, acc_q);

  pe_alu #(.DW(DW)) u_alu (
    .op1    (op1),
    .op2    (op2),
    .opcode (cur.opcode),
    .result (result)
  );

  // Next-state: FSM transitions, context sequencing and masked result capture.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    out_d   = out_q;
    vld_d   = '0;
    if (state_q == ST_IDLE) begin
      idx_d = '0;
      if (run) state_d = ST_RUN;
    end else if (!run) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else if (fire) begin
      for (int p = 0; p < 4; p++) begin
        if (cur.out_mask[p]) out_d[p] = result;
      end
      vld_d = cur.out_mask;
      if (cur.acc_wr) acc_d = result;
      if (cur.last || (idx_q == AW'(CTX_DEPTH - 1))) idx_d = '0;
      else                                           idx_d = idx_q + AW'(1);
    end
  end

  // Datapath and FSM registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      vld_q   <= '0;
      for (int p = 0; p < 4; p++) out_q[p] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      vld_q   <= vld_d;
      out_q   <= out_d;
    end
  end

  // Context memory; writes accepted in any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CTX_DEPTH; i++) ctx_q[i] <= '0;
    end else if (cfg_we && (int'(cfg_addr) < CTX_DEPTH)) begin
      ctx_q[cfg_addr] <= pe_cfg_t'(cfg_data);
    end
  end

  assign out_e     = out_q[DIR_E];
  assign out_s     = out_q[DIR_S];
  assign out_w     = out_q[DIR_W];
  assign out_n     = out_q[DIR_N];
  assign out_valid = vld_q;
  assign acc       = acc_q;
  assign ctx_idx   = idx_q;
  assign busy      = (state_q == ST_RUN);

endmodule

// File: tb/tb_pe_ctx.sv
// Directed self-checking bench for pe_ctx (DW=8, CTX_DEPTH=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants.
module tb_pe_ctx;

  logic       clk, rst;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [15:0] cfg_data;
  logic       run, in_valid;
  logic [7:0] in_e, in_s, in_w, in_n;
  logic [7:0] out_e, out_s, out_w, out_n, acc;
  logic [3:0] out_valid;
  logic [1:0] ctx_idx;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  pe_ctx #(.DW(8), .CTX_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .run(run), .in_valid(in_valid),
    .in_e(in_e), .in_s(in_s), .in_w(in_w), .in_n(in_n),
    .out_e(out_e), .out_s(out_s), .out_w(out_w), .out_n(out_n),
    .out_valid(out_valid), .acc(acc), .ctx_idx(ctx_idx), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [3:0] m, input logic [2:0] a,
                                     input logic [2:0] b, input logic [2:0] op,
                                     input logic aw, input logic l);
    return {m, a, b, op, aw, l, 1'b0};
  endfunction

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got 0x0, expected 0x1");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    run = 1'b1; in_valid = 1'b1;
    in_e = 8'h55; in_s = 8'h55; in_w = 8'h55; in_n = 8'h55;
    #2; tick(); tick();
    check("rst_out_e", out_e, 0);
    check("rst_out_s", out_s, 0);
    check("rst_out_w", out_w, 0);
    check("rst_out_n", out_n, 0);
    check("rst_vld",   out_valid, 0);
    check("rst_acc",   acc, 0);
    check("rst_idx",   ctx_idx, 0);
    check("rst_busy",  busy, 0);
    run = 1'b0; in_valid = 1'b0; rst = 1'b0;
    tick();

    // ADD: E+S to port E, single-context program
    cfg_write(2'd0, mk(4'b0001, 3'd0, 3'd1, 3'd0, 1'b0, 1'b1));
    in_e = 8'hAA; in_s = 8'hCC; run = 1'b1;
    tick();
    check("run_busy", busy, 1);
    check("run_vld0", out_valid, 0);
    in_valid = 1'b1;
    tick();
    check("add_out_e", out_e, 8'h76);
    check("add_vld",   out_valid, 4'b0001);
    check("add_idx",   ctx_idx, 0);
    in_valid = 1'b0;
    tick();
    check("add_pulse", out_valid, 0);
    check("add_hold",  out_e, 8'h76);

    // SUB then MUL over two contexts
    cfg_write(2'd0, mk(4'b0010, 3'd1, 3'd2, 3'd1, 1'b0, 1'b0));
    cfg_write(2'd1, mk(4'b0110, 3'd1, 3'd2, 3'd2, 1'b0, 1'b1));
    in_s = 8'hCC; in_w = 8'hF0; in_valid = 1'b1;
    tick();
    check("sub_out_s", out_s, 8'hDC);
    check("sub_vld",   out_valid, 4'b0010);
    check("sub_idx",   ctx_idx, 1);
    tick();
    check("mul_out_s", out_s, 8'h40);
    check("mul_out_w", out_w, 8'h40);
    check("mul_vld",   out_valid, 4'b0110);
    check("mul_idx",   ctx_idx, 0);
    check("mul_e_hold", out_e, 8'h76);
    in_valid = 1'b0;

    // Accumulate: acc <= acc + N, no output ports
    cfg_write(2'd0, mk(4'b0000, 3'd4, 3'd3, 3'd0, 1'b1, 1'b1));
    in_n = 8'h0F; in_valid = 1'b1;
    tick(); check("acc1", acc, 8'h0F); check("acc1_vld", out_valid, 0);
    tick(); check("acc2", acc, 8'h1E);
    tick(); check("acc3", acc, 8'h2D); check("acc3_vld", out_valid, 0);
    check("acc_idx", ctx_idx, 0);
    in_valid = 1'b0;

    // Four-context sequence with a two-cycle stall at ctx 2
    cfg_write(2'd0, mk(4'b0001, 3'd0, 3'd5, 3'd6, 1'b0, 1'b0)); // PASS E
    cfg_write(2'd1, mk(4'b0010, 3'd4, 3'd5, 3'd4, 1'b0, 1'b0)); // ACC | 0
    cfg_write(2'd2, mk(4'b0100, 3'd0, 3'd1, 3'd3, 1'b0, 1'b0)); // E & S
    cfg_write(2'd3, mk(4'b1000, 3'd0, 3'd1, 3'd7, 1'b0, 1'b0)); // MAX(E,S)
    in_e = 8'hAA; in_s = 8'hCC; in_valid = 1'b1;
    tick(); check("seq0_out_e", out_e, 8'hAA); check("seq0_idx", ctx_idx, 1);
    tick(); check("seq1_out_s", out_s, 8'h2D); check("seq1_idx", ctx_idx, 2);
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("stall_idx",  ctx_idx, 2);
      check("stall_vld",  out_valid, 0);
      check("stall_out_w", out_w, 8'h40);
    end
    in_valid = 1'b1;
    tick(); check("seq2_out_w", out_w, 8'h88); check("seq2_vld", out_valid, 4'b0100);
    check("seq2_idx", ctx_idx, 3);
    tick(); check("seq3_out_n", out_n, 8'hCC); check("seq3_vld", out_valid, 4'b1000);
    check("seq3_wrap", ctx_idx, 0);
    in_e = 8'h11;
    tick(); check("seq4_out_e", out_e, 8'h11); check("seq4_idx", ctx_idx, 1);

    // Rewrite ctx1 to XOR in the very cycle ctx1 fires
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = mk(4'b0010, 3'd0, 3'd1, 3'd5, 1'b0, 1'b0);
    tick();
    cfg_we = 1'b0;
    check("coll_old", out_s, 8'h2D);
    tick(); check("coll_and", out_w, 8'h00);
    tick(); tick(); tick();
    check("coll_xor", out_s, 8'hDD);
    check("coll_vld", out_valid, 4'b0010);

    // Drop run: back to IDLE after one edge, no fire
    run = 1'b0;
    tick();
    check("idle_busy", busy, 0);
    check("idle_idx",  ctx_idx, 0);
    check("idle_vld",  out_valid, 0);
    check("idle_hold", out_s, 8'hDD);
    check("idle_acc",  acc, 8'h2D);

    // Asynchronous reset between edges while running
    run = 1'b1;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("arst_out_e", out_e, 0);
    check("arst_out_s", out_s, 0);
    check("arst_acc",   acc, 0);
    check("arst_busy",  busy, 0);
    #1 rst = 1'b0;
    #1 check("arst_rel_busy", busy, 0);
    tick();
    check("rerun_busy", busy, 1);
    // Cleared ctx0: mask 0, last 0 -> no valid, pointer advances
    tick();
    check("clr_vld", out_valid, 0);
    check("clr_idx", ctx_idx, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
